// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-end: button indices, button count,
// debounce state encoding and a counter-width helper.
package clock_pkg;

    localparam int BTN_U   = 0;
    localparam int BTN_D   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_L   = 3;
    localparam int BTN_C   = 4;
    localparam int NUM_BTN = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } deb_state_t;

    // Width of a counter that must hold max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: two-flop synchroniser, tick-qualified debounce FSM and a
// registered one-cycle press pulse. With BTN_AUTOREPEAT_EN defined the cell
// also carries a repeat timer that fires while the button stays in HELD.
module debounce_cell
    import clock_pkg::*;
#(
`ifdef BTN_AUTOREPEAT_EN
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 40,
    parameter bit REPEAT_EN    = 1'b0,
`endif
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       raw,
    output logic       level,
    output logic       pulse,
    output deb_state_t state
);

    localparam int            CW       = cnt_width(DEBOUNCE_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SAMPLES);

    logic          sync1, sync2;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_d;

`ifdef BTN_AUTOREPEAT_EN
    // After the first repeat the timer is pulled back so the next pulse lands
    // REPEAT_RATE ticks later; a rate longer than the delay collapses to the delay.
    localparam int            RPT_RELOAD = (REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0;
    localparam int            RW         = cnt_width(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_ONE    = RW'(1);
    localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_BACK   = RW'(RPT_RELOAD);

    logic [RW-1:0] rpt_q, rpt_d;
`endif

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // State, sample counter, repeat timer and registered pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    // Next-state logic; only a tick cycle may move the FSM or raise a pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (sync2) begin
                        state_d = PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS: begin
                    if (!sync2) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync2) begin
                        state_d = RELEASE;
                        cnt_d   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (REPEAT_EN) begin
                        if (rpt_q + RPT_ONE == RPT_FIRST) begin
                            pulse_d = 1'b1;
                            rpt_d   = RPT_BACK;
                        end else begin
                            rpt_d = rpt_q + RPT_ONE;
                        end
                    end
`endif
                end
                RELEASE: begin
                    if (sync2) begin
                        // Bounce during release: stay pressed, no new pulse.
                        state_d = HELD;
                        cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign level = (state_q == HELD) || (state_q == RELEASE);
    assign state = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: a shared sample-tick divider feeding one
// debounce_cell per button. Optional auto-repeat is enabled by defining
// BTN_AUTOREPEAT_EN; without it each debounced press gives exactly one pulse.
// Output contract: btn_pulse bits are one-cycle strobes with no backpressure;
// a consumer must act on the cycle a bit is high. btn_level is a plain level.
module button_conditioner #(
    parameter int                   NUM_BTN          = clock_pkg::NUM_BTN,
    parameter int                   SAMPLE_DIV       = 250000,
    parameter int                   DEBOUNCE_SAMPLES = 4,
    parameter int                   REPEAT_DELAY     = 200,
    parameter int                   REPEAT_RATE      = 40,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK      = NUM_BTN'(5'b00011)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               tick
);
    import clock_pkg::*;

    localparam int            TW        = cnt_width(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tick_cnt;

    // Per-cell FSM state, kept visible for probing.
    deb_state_t dbg_state_unused [NUM_BTN];

    // Free-running sample divider; tick is high while the count sits at its top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

`ifndef BTN_AUTOREPEAT_EN
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0) ^ (|REPEAT_MASK);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
`ifdef BTN_AUTOREPEAT_EN
            .REPEAT_DELAY     (REPEAT_DELAY),
            .REPEAT_RATE      (REPEAT_RATE),
            .REPEAT_EN        (REPEAT_MASK[i]),
`endif
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i]),
            .state (dbg_state_unused[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short tick (SAMPLE_DIV=4, 3 samples,
// repeat delay 5 / rate 2). Stimulus is driven on the falling edge of a tick
// cycle (drive point j); the k-th later tick evaluation lands on cycle
// c0 + 1 + 4*k, which is where expected pulses are scheduled.
module tb_button_conditioner;

    localparam int NB    = 5;
    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int RDEL  = 5;
    localparam int RRATE = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          tick;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [NB-1:0] exp_q[$];
    int            exp_cyc_q[$];

    button_conditioner #(
        .NUM_BTN          (NB),
        .SAMPLE_DIV       (SDIV),
        .DEBOUNCE_SAMPLES (DEB),
        .REPEAT_DELAY     (RDEL),
        .REPEAT_RATE      (RRATE),
        .REPEAT_MASK      (5'b00011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .tick      (tick)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got no end of test required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Monitor: every pulse must match the head of the expected queue, vector and cycle.
    always @(negedge clk) begin
        if (btn_pulse != '0) begin
            logic [NB-1:0] e;
            int            ec;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b required none", cyc, btn_pulse);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (btn_pulse !== e || cyc != ec) begin
                    errors++;
                    $display("FAIL pulse cyc=%0d got=%b required %b at cyc %0d", cyc, btn_pulse, e, ec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic expect_pulse(input logic [NB-1:0] vec, input int at_cyc);
        exp_q.push_back(vec);
        exp_cyc_q.push_back(at_cyc);
    endtask

    function automatic int at_tick(input int c0, input int k);
        return c0 + 1 + SDIV * k;
    endfunction

    // Advance to the falling edge inside the next tick cycle.
    task automatic next_tick();
        int guard;
        guard = 0;
        @(negedge clk);
        while (tick !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout cyc=%0d got tick=%b required 1", cyc, tick);
        end
    endtask

    initial begin
        int c0;
        int c1;

        // 1: reset with all pins high, then the first tick after release.
        rst     = 1'b0;
        btn_raw = 5'h1F;
        repeat (3) @(negedge clk);
        check("reset_level", btn_level, 5'h00);
        check("reset_pulse", btn_pulse, 5'h00);
        check("reset_tick", tick, 1'b0);
        btn_raw = '0;
        rst     = 1'b1;
        check("tick_cycle1", tick, 1'b0);
        @(negedge clk);
        check("tick_cycle2", tick, 1'b0);
        @(negedge clk);
        check("tick_cycle3", tick, 1'b0);
        @(negedge clk);
        check("tick_cycle4", tick, 1'b1);

        // 2: clean press of U for 10 ticks.
        next_tick();
        c0      = cyc;
        btn_raw = 5'b00001;
        expect_pulse(5'b00001, at_tick(c0, 3));
`ifdef BTN_AUTOREPEAT_EN
        expect_pulse(5'b00001, at_tick(c0, 8));
        expect_pulse(5'b00001, at_tick(c0, 10));
`endif
        repeat (5) next_tick();
        check("clean_level_held", btn_level, 5'b00001);
        repeat (5) next_tick();
        btn_raw = '0;
        c1      = cyc;
        repeat (12) @(negedge clk);
        check("clean_level_release_pending", btn_level, 5'b00001);
        @(negedge clk);
        check("clean_level_released", btn_level, 5'b00000);

        // 3: C bounces 1,0,1,0 then holds.
        next_tick();
        c0      = cyc;
        btn_raw = 5'b10000;
        expect_pulse(5'b10000, at_tick(c0, 7));
        next_tick();
        btn_raw = 5'b00000;
        next_tick();
        btn_raw = 5'b10000;
        next_tick();
        btn_raw = 5'b00000;
        next_tick();
        btn_raw = 5'b10000;
        repeat (5) next_tick();
        check("bounce_level_held", btn_level, 5'b10000);
        next_tick();
        btn_raw = '0;
        repeat (4) next_tick();
        check("bounce_level_released", btn_level, 5'b00000);

        // 4: U and L together.
        next_tick();
        c0      = cyc;
        btn_raw = 5'b01001;
        expect_pulse(5'b01001, at_tick(c0, 3));
        repeat (4) next_tick();
        check("simul_level", btn_level, 5'b01001);
        next_tick();
        btn_raw = '0;
        repeat (4) next_tick();
        check("simul_level_released", btn_level, 5'b00000);

        // 5: hold D for 20 ticks.
        next_tick();
        c0      = cyc;
        btn_raw = 5'b00010;
        expect_pulse(5'b00010, at_tick(c0, 3));
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 8; k <= 20; k += 2) expect_pulse(5'b00010, at_tick(c0, k));
`endif
        repeat (20) next_tick();
        check("repeat_level_held", btn_level, 5'b00010);
        btn_raw = '0;
        repeat (4) next_tick();
        check("repeat_level_released", btn_level, 5'b00000);

        // 6: reset while R is held, then re-debounce after release.
        next_tick();
        c0      = cyc;
        btn_raw = 5'b00100;
        expect_pulse(5'b00100, at_tick(c0, 3));
        repeat (5) next_tick();
        check("midhold_level_before", btn_level, 5'b00100);
        rst = 1'b0;
        #1;
        check("midhold_level_in_reset", btn_level, 5'b00000);
        check("midhold_pulse_in_reset", btn_pulse, 5'b00000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        c1  = cyc;
        expect_pulse(5'b00100, c1 + 12);
        repeat (20) @(negedge clk);
        check("midhold_level_after", btn_level, 5'b00100);
        btn_raw = '0;
        repeat (6) next_tick();
        check("midhold_level_released", btn_level, 5'b00000);

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses got %0d outstanding required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
